// File: rtl/mem_port_arbiter.sv
// Shares the single DataMem port between instruction fetch (IF) and load/store (LS).
// One outstanding transaction, LS priority with IF anti-starvation, response timeout.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_func3,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          owner_ls;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          pick_if;
  logic          pick_ls;
  logic [31:0]   resp_data;

  always_comb begin
    pick_if   = if_req && (!ls_req || (starve_cnt == STARVE_MAX));
    pick_ls   = ls_req && !pick_if;
    // Stores and timeouts both return zero data.
    resp_data = (mem_rvalid && !mem_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_ls   <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_func3  <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      mem_req   <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          // Counts LS wins that left IF waiting; any other outcome clears it.
          if (pick_ls && if_req)
            starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
          else
            starve_cnt <= '0;
          if (pick_if || pick_ls) begin
            owner_ls  <= pick_ls;
            if_gnt    <= pick_if;
            ls_gnt    <= pick_ls;
            mem_req   <= 1'b1;
            mem_we    <= pick_ls && ls_we;
            mem_addr  <= pick_ls ? ls_addr : if_addr;
            mem_wdata <= pick_ls ? ls_wdata : '0;
            mem_func3 <= pick_ls ? ls_func3 : 3'b010;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid || (tmo_cnt == TMO_LAST)) begin
            if (owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= resp_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= resp_data;
            end
            err   <= !mem_rvalid;
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single data/instruction memory port between two requesters: the instruction-fetch stage (IF) and the load/store stage (LS).
- Allows one outstanding transaction at a time, with variable memory latency and a response timeout.
- LS has fixed priority over IF. An anti-starvation counter guarantees IF progress.
- Sits between the pipeline stages and DataMem.

Parameters:
- STARVE_LIMIT, 4: consecutive LS grants while IF waits before IF is forced to win.
- TIMEOUT, 16: cycles in WAIT without mem_rvalid before the transaction is aborted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch address
- if_gnt  out  1  one-cycle pulse: IF request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- ls_req  in  1  load/store request; held with fields until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  32  data address
- ls_wdata  in  32  store data
- ls_func3  in  3  access size/sign (RISC-V func3), passed through to memory
- ls_gnt  out  1  one-cycle pulse: LS request accepted
- ls_rvalid  out  1  one-cycle pulse: load data or store ack ready
- ls_rdata  out  32  load data (0 for stores)
- mem_req  out  1  one-cycle pulse launching a memory transaction
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  32  address, held from launch until completion
- mem_wdata  out  32  write data, held from launch until completion
- mem_func3  out  3  access size, held from launch until completion
- mem_rvalid  in  1  memory completion (loads and stores)
- mem_rdata  in  32  read data, valid with mem_rvalid
- err  out  1  one-cycle pulse on timeout abort
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - state = IDLE, owner = IF, starve_cnt = 0, tmo_cnt = 0.
  - All outputs are 0: mem_addr, mem_wdata, mem_func3 = 0, and all pulses/valids = 0.
  - Reset mid-transaction abandons it. No rvalid or err is emitted for it.
  - A late mem_rvalid arriving in IDLE is ignored.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitration if ls_req and if_req both high: IF wins when starve_cnt == STARVE_LIMIT, otherwise LS wins.
  - Only one requester high: that requester wins.
  - On a win, latch owner and the winner's fields, then go to ISSUE.
  - IF transactions always use mem_we = 0 and mem_func3 = 3'b010 (word).
- ISSUE (one cycle): mem_req = 1 and owner's gnt = 1 in this same cycle. tmo_cnt = 0. Go to WAIT.
- WAIT:
  - mem_rvalid: capture mem_rdata (0 if store) and go to RESP.
  - Otherwise tmo_cnt increments. When tmo_cnt reaches TIMEOUT-1 with no mem_rvalid, go to RESP with rdata = 0 and err pulsed together with the rvalid.
- RESP (one cycle): owner's rvalid = 1 and owner's rdata = captured data. Go to IDLE.
  - Arbitration for the next request happens in the following IDLE cycle, so minimum spacing between mem_req pulses is 4 cycles when memory replies in 1 cycle.
- Latency: request seen in IDLE at cycle t gives gnt and mem_req at t+1; mem_rvalid at t+1+L gives rvalid at t+2+L (L ≥ 1).
- mem_rvalid in the same cycle as mem_req (ISSUE) is ignored; memory latency is ≥ 1.
- Starvation counter, updated at each IDLE arbitration decision:
  - LS granted while if_req high: starve_cnt += 1, saturating at STARVE_LIMIT.
  - IF granted, or if_req low: starve_cnt = 0.
- The non-owner's gnt and rvalid never pulse. At most one gnt and one rvalid per cycle across both requesters.
- A requester dropping req before gnt withdraws the request; this is legal.
- Fields are sampled only in IDLE. Changes after gnt have no effect.
- Both rdata outputs hold their last value except during reset.

Test Plan:
- Single LS load to 0x100, memory latency 2, mem_rdata = 0xDEADBEEF:
  - Required: ls_gnt and mem_req at t+1 with mem_we = 0 and mem_addr = 0x100; ls_rvalid = 1 and ls_rdata = 0xDEADBEEF at t+4; busy high t+1..t+4.
- Simultaneous if_req/ls_req held continuously, STARVE_LIMIT = 4, latency 1:
  - Required: grant order LS, LS, LS, LS, IF, LS…; starve_cnt resets after the IF grant.
- LS store of 0x12345678 at 0x200 with func3 = 3'b000:
  - Required: mem_we = 1, mem_wdata = 0x12345678, mem_func3 = 0; ls_rvalid with ls_rdata = 0; if_rvalid stays 0.
- IF fetch with mem_rvalid never asserted, TIMEOUT = 16:
  - Required: if_rvalid = 1, if_rdata = 0 and err = 1 in the same cycle; then IDLE and the next request is accepted normally.
- Reset asserted while in WAIT for an LS load, then mem_rvalid arrives 2 cycles after reset release:
  - Required: no ls_rvalid and no err; all outputs 0; state IDLE.
- Back-to-back IF fetches, latency 1:
  - Required: mem_req pulses exactly 4 cycles apart; if_rdata matches each mem_rdata in order.
